// File: rtl/bisect_sched_if.sv
// -----------------------------------------------------------------------------
// bisect_sched_if
// Bundles the signals between the bisect scheduler and its surroundings.
// A triangle is a flat vector of three vertices, each {x, y, z} of COORD_W
// bits, packed as {p, q, r} with p in the most significant bits.
//
// Signals (direction as seen from the scheduler, modport slave):
//   tri_in        in   source triangle
//   in_valid      in   tri_in valid
//   in_ready      out  scheduler can accept a source triangle
//   depth_cfg     in   subdivision level, sampled on accept
//   tri_out       out  leaf triangle
//   out_valid     out  tri_out valid
//   out_ready     in   consumer accepts tri_out
//   bis_tri_in    out  triangle driven to the bisect datapath
//   bis_tri_select out 0 selects half A, 1 selects half B
//   bis_tri_out   in   bisect result, registered, one-cycle latency
//   busy          out  scheduler not idle
//   done          out  one-cycle pulse after the last leaf of a source
// -----------------------------------------------------------------------------
interface bisect_sched_if #(
    parameter int COORD_W = 16
);
    localparam int TRI_W = 9 * COORD_W;

    logic [TRI_W-1:0] tri_in;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       depth_cfg;
    logic [TRI_W-1:0] tri_out;
    logic             out_valid;
    logic             out_ready;
    logic [TRI_W-1:0] bis_tri_in;
    logic             bis_tri_select;
    logic [TRI_W-1:0] bis_tri_out;
    logic             busy;
    logic             done;

    modport slave (
        input  tri_in, in_valid, depth_cfg, out_ready, bis_tri_out,
        output in_ready, tri_out, out_valid, bis_tri_in, bis_tri_select,
               busy, done
    );

    modport master (
        output tri_in, in_valid, depth_cfg, out_ready, bis_tri_out,
        input  in_ready, tri_out, out_valid, bis_tri_in, bis_tri_select,
               busy, done
    );
endinterface

// File: rtl/bisect_sched.sv
// -----------------------------------------------------------------------------
// bisect_sched
// Depth-first subdivision controller. A source triangle is pushed onto a LIFO
// stack with level 0; entries are popped, split through an external bisect
// datapath until they reach the latched depth, and emitted as leaves. Half A
// is pushed last so it is popped (and emitted) before half B.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   bisect_sched_if.slave: upstream, downstream and bisect datapath
//         handshakes plus busy/done status
// -----------------------------------------------------------------------------
module bisect_sched #(
    parameter int MAX_DEPTH   = 7,
    parameter int STACK_DEPTH = MAX_DEPTH + 1,
    parameter int COORD_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    bisect_sched_if.slave  bus
);
    localparam int TRI_W = 9 * COORD_W;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0]      MAX_D3 = 3'(MAX_DEPTH);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        IDLE, FETCH, SPLIT_A, SPLIT_B, PUSH_B, PUSH_A, EMIT, FIN
    } state_t;

    state_t           state_q, state_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [2:0]       depth_q, depth_d;
    logic [TRI_W-1:0] work_q, work_d;
    logic [2:0]       work_lvl_q, work_lvl_d;
    logic [TRI_W-1:0] halfa_q, halfa_d;

    // Stack storage: triangle and level kept side by side per entry.
    logic [TRI_W-1:0] tri_mem [STACK_DEPTH];
    logic [2:0]       lvl_mem [STACK_DEPTH];

    logic             push_en;
    logic [TRI_W-1:0] push_tri;
    logic [2:0]       push_lvl;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             stack_full;
    logic [2:0]       cfg_depth;

    assign wr_idx     = IDX_W'(sp_q);
    assign rd_idx     = IDX_W'(sp_q - SP_W'(1));
    assign stack_full = (sp_q == SP_FULL);
    // A depth request beyond what the stack was sized for is clamped.
    assign cfg_depth  = (bus.depth_cfg > MAX_D3) ? MAX_D3 : bus.depth_cfg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sp_q       <= '0;
            depth_q    <= '0;
            work_q     <= '0;
            work_lvl_q <= '0;
            halfa_q    <= '0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            depth_q    <= depth_d;
            work_q     <= work_d;
            work_lvl_q <= work_lvl_d;
            halfa_q    <= halfa_d;
        end
    end

    // Stack contents need no reset: sp_q alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            tri_mem[wr_idx] <= push_tri;
            lvl_mem[wr_idx] <= push_lvl;
        end
    end

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        depth_d    = depth_q;
        work_d     = work_q;
        work_lvl_d = work_lvl_q;
        halfa_d    = halfa_q;
        push_en    = 1'b0;
        push_tri   = '0;
        push_lvl   = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    push_en  = 1'b1;
                    push_tri = bus.tri_in;
                    push_lvl = 3'd0;
                    sp_d     = sp_q + SP_W'(1);
                    depth_d  = cfg_depth;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (sp_q == '0) begin
                    state_d = FIN;
                end else begin
                    work_d     = tri_mem[rd_idx];
                    work_lvl_d = lvl_mem[rd_idx];
                    sp_d       = sp_q - SP_W'(1);
                    state_d    = (lvl_mem[rd_idx] >= depth_q) ? EMIT : SPLIT_A;
                end
            end
            SPLIT_A: begin
                state_d = SPLIT_B;
            end
            SPLIT_B: begin
                // Half A, requested in SPLIT_A, is on bis_tri_out now.
                halfa_d = bus.bis_tri_out;
                state_d = PUSH_B;
            end
            PUSH_B: begin
                // Half B, requested in SPLIT_B, is on bis_tri_out now.
                if (!stack_full) begin
                    push_en  = 1'b1;
                    push_tri = bus.bis_tri_out;
                    push_lvl = work_lvl_q + 3'd1;
                    sp_d     = sp_q + SP_W'(1);
                end
                state_d = PUSH_A;
            end
            PUSH_A: begin
                if (!stack_full) begin
                    push_en  = 1'b1;
                    push_tri = halfa_q;
                    push_lvl = work_lvl_q + 3'd1;
                    sp_d     = sp_q + SP_W'(1);
                end
                state_d = FETCH;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    state_d = FETCH;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // work_q is only updated in FETCH, so the leaf stays stable through EMIT.
    assign bus.tri_out        = work_q;
    assign bus.bis_tri_in     = work_q;
    assign bus.bis_tri_select = (state_q == SPLIT_B);
    assign bus.in_ready       = (state_q == IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.out_valid      = (state_q == EMIT);
    assign bus.done           = (state_q == FIN);
endmodule

// File: tb/tb_bisect_sched.sv
module tb_bisect_sched;
    localparam int COORD_W = 16;
    localparam int TRI_W   = 9 * COORD_W;
    typedef logic [TRI_W-1:0] tri_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bisect_sched_if #(.COORD_W(COORD_W)) bus ();

    bisect_sched #(
        .MAX_DEPTH   (7),
        .STACK_DEPTH (8),
        .COORD_W     (COORD_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Collection results
    tri_t leaves[$];
    int   done_cnt;
    int   max_sp;
    int   first_valid;
    bit   inready_while_busy;

    function automatic tri_t mk(input int px, input int py, input int pz,
                                input int qx, input int qy, input int qz,
                                input int rx, input int ry, input int rz);
        return {16'(px), 16'(py), 16'(pz), 16'(qx), 16'(qy), 16'(qz),
                16'(rx), 16'(ry), 16'(rz)};
    endfunction

    function automatic logic [47:0] midv(input logic [47:0] a, input logic [47:0] b);
        logic [47:0] m;
        for (int k = 0; k < 3; k++) begin
            logic [16:0] s;
            s = {1'b0, a[k*16 +: 16]} + {1'b0, b[k*16 +: 16]};
            m[k*16 +: 16] = s[16:1];
        end
        return m;
    endfunction

    // Reference bisect datapath: splits edge p-q at its (floored) midpoint.
    function automatic tri_t bisect(input tri_t t, input logic sel);
        logic [47:0] p, q, r, m;
        p = t[143:96];
        q = t[95:48];
        r = t[47:0];
        m = midv(p, q);
        return sel ? {m, q, r} : {p, m, r};
    endfunction

    always @(posedge clk) begin
        bus.bis_tri_out <= bisect(bus.bis_tri_in, bus.bis_tri_select);
    end

    tri_t src_t, leaf_a, leaf_b, d3_first, d3_last, src2_t;

    task automatic start(input tri_t t, input logic [2:0] d, input bit hold);
        @(negedge clk);
        bus.tri_in    = t;
        bus.depth_cfg = d;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
        $display("accept depth=%0d tri=%h", d, t);
    endtask

    // Gathers leaves until done is seen (plus a few trailing cycles), or the
    // budget expires. Pure observation; judgements happen in the tests.
    task automatic collect(input int budget);
        int stop_at;
        stop_at = budget;
        leaves.delete();
        done_cnt = 0;
        max_sp = 0;
        first_valid = -1;
        inready_while_busy = 1'b0;
        for (int c = 0; c < stop_at; c++) begin
            @(negedge clk);
            if (int'(dut.sp_q) > max_sp) max_sp = int'(dut.sp_q);
            if (bus.busy && bus.in_ready) inready_while_busy = 1'b1;
            if (bus.out_valid && first_valid < 0) first_valid = c;
            if (bus.out_valid && bus.out_ready) begin
                leaves.push_back(bus.tri_out);
                $display("leaf %0d tri=%h", leaves.size() - 1, bus.tri_out);
            end
            if (bus.done) begin
                done_cnt++;
                bus.in_valid = 1'b0;
                $display("done pulse");
                if (stop_at == budget) stop_at = c + 4;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.bis_tri_select !== 1'b0) begin errors++; $display("FAIL reset_select got %b want 0", bus.bis_tri_select); end
        checks++; if (bus.tri_out !== '0) begin errors++; $display("FAIL reset_tri_out got %h want 0", bus.tri_out); end
        checks++; if (bus.bis_tri_in !== '0) begin errors++; $display("FAIL reset_bis_tri_in got %h want 0", bus.bis_tri_in); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_depth0();
        int lat;
        start(src_t, 3'd0, 1'b0);
        collect(30);
        // FETCH is the first cycle after the accept edge, EMIT the second.
        lat = first_valid + 2;
        checks++; if (lat !== 2) begin errors++; $display("FAIL d0_latency got %0d want 2", lat); end
        checks++; if (leaves.size() !== 1) begin errors++; $display("FAIL d0_count got %0d want 1", leaves.size()); end
        if (leaves.size() >= 1) begin
            checks++; if (leaves[0] !== src_t) begin errors++; $display("FAIL d0_leaf got %h want %h", leaves[0], src_t); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL d0_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_depth1();
        start(src_t, 3'd1, 1'b0);
        collect(60);
        checks++; if (leaves.size() !== 2) begin errors++; $display("FAIL d1_count got %0d want 2", leaves.size()); end
        if (leaves.size() >= 2) begin
            checks++; if (leaves[0] !== leaf_a) begin errors++; $display("FAIL d1_leaf_a got %h want %h", leaves[0], leaf_a); end
            checks++; if (leaves[1] !== leaf_b) begin errors++; $display("FAIL d1_leaf_b got %h want %h", leaves[1], leaf_b); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL d1_done got %0d want 1", done_cnt); end
        checks++; if (max_sp !== 2) begin errors++; $display("FAIL d1_max_sp got %0d want 2", max_sp); end
    endtask

    task automatic test_depth3();
        start(src_t, 3'd3, 1'b0);
        collect(300);
        checks++; if (leaves.size() !== 8) begin errors++; $display("FAIL d3_count got %0d want 8", leaves.size()); end
        if (leaves.size() == 8) begin
            checks++; if (leaves[0] !== d3_first) begin errors++; $display("FAIL d3_first got %h want %h", leaves[0], d3_first); end
            checks++; if (leaves[7] !== d3_last) begin errors++; $display("FAIL d3_last got %h want %h", leaves[7], d3_last); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL d3_done got %0d want 1", done_cnt); end
        checks++; if (max_sp !== 4) begin errors++; $display("FAIL d3_max_sp got %0d want 4", max_sp); end
        checks++; if (inready_while_busy !== 1'b0) begin errors++; $display("FAIL d3_in_ready_busy got %b want 0", inready_while_busy); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        start(src_t, 3'd1, 1'b0);
        for (int c = 0; c < 30 && !bus.out_valid; c++) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_wait_valid got %b want 1", bus.out_valid); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", c, bus.out_valid); end
            checks++; if (bus.tri_out !== leaf_a) begin errors++; $display("FAIL bp_hold_tri cycle %0d got %h want %h", c, bus.tri_out, leaf_a); end
        end
        bus.out_ready = 1'b1;
        $display("leaf held tri=%h released", bus.tri_out);
        collect(60);
        checks++; if (leaves.size() !== 1) begin errors++; $display("FAIL bp_rest_count got %0d want 1", leaves.size()); end
        if (leaves.size() >= 1) begin
            checks++; if (leaves[0] !== leaf_b) begin errors++; $display("FAIL bp_leaf_b got %h want %h", leaves[0], leaf_b); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int stray;
        start(src_t, 3'd2, 1'b0);
        for (int c = 0; c < 20 && !bus.bis_tri_select; c++) @(negedge clk);
        checks++; if (bus.bis_tri_select !== 1'b1) begin errors++; $display("FAIL rm_reach_split_b got %b want 1", bus.bis_tri_select); end
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.bis_tri_select !== 1'b0) begin errors++; $display("FAIL rm_select got %b want 0", bus.bis_tri_select); end
        checks++; if (bus.bis_tri_in !== '0) begin errors++; $display("FAIL rm_bis_tri_in got %h want 0", bus.bis_tri_in); end
        checks++; if (bus.tri_out !== '0) begin errors++; $display("FAIL rm_tri_out got %h want 0", bus.tri_out); end
        checks++; if (int'(dut.sp_q) !== 0) begin errors++; $display("FAIL rm_sp got %0d want 0", dut.sp_q); end
        stray = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.out_valid || bus.done) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rm_quiet got %0d want 0", stray); end
        // Release reset and offer a triangle in the same cycle.
        rst = 1'b0;
        bus.tri_in    = src2_t;
        bus.depth_cfg = 3'd0;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("accept depth=0 tri=%h after reset", src2_t);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_first_accept got %b want 1", bus.busy); end
        collect(30);
        checks++; if (leaves.size() !== 1) begin errors++; $display("FAIL rm_count got %0d want 1", leaves.size()); end
        if (leaves.size() >= 1) begin
            checks++; if (leaves[0] !== src2_t) begin errors++; $display("FAIL rm_leaf got %h want %h", leaves[0], src2_t); end
        end
    endtask

    task automatic test_busy_ignore();
        start(src_t, 3'd1, 1'b1);
        bus.depth_cfg = 3'd3;
        collect(80);
        checks++; if (leaves.size() !== 2) begin errors++; $display("FAIL bi_count got %0d want 2", leaves.size()); end
        if (leaves.size() >= 2) begin
            checks++; if (leaves[1] !== leaf_b) begin errors++; $display("FAIL bi_leaf_b got %h want %h", leaves[1], leaf_b); end
        end
        checks++; if (inready_while_busy !== 1'b0) begin errors++; $display("FAIL bi_in_ready_busy got %b want 0", inready_while_busy); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bi_done got %0d want 1", done_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bi_idle_after got %b want 0", bus.busy); end
    endtask

    initial begin
        bus.tri_in    = '0;
        bus.in_valid  = 1'b0;
        bus.depth_cfg = 3'd0;
        bus.out_ready = 1'b1;

        src_t    = mk(115, 56, 0, 346, 850, 0, 310, 450, 0);
        leaf_a   = mk(115, 56, 0, 230, 453, 0, 310, 450, 0);
        leaf_b   = mk(230, 453, 0, 346, 850, 0, 310, 450, 0);
        d3_first = mk(115, 56, 0, 143, 155, 0, 310, 450, 0);
        d3_last  = mk(317, 750, 0, 346, 850, 0, 310, 450, 0);
        src2_t   = mk(10, 20, 30, 40, 50, 60, 70, 80, 90);

        test_reset();
        test_depth0();
        test_depth1();
        test_depth3();
        test_backpressure();
        test_reset_mid();
        test_busy_ignore();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bisect_sched.md
BISECT_SCHED -- requirements
Module: bisect_sched

Interface
REQ-001 SHALL have parameter MAX_DEPTH, default 7, maximum subdivision level; depth_cfg is 3 bits.
REQ-002 SHALL have parameter STACK_DEPTH, default MAX_DEPTH+1, number of triangle stack entries.
REQ-003 SHALL have one clock and an asynchronous, active-high reset:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have these upstream ports:
- tri_in  input  Triangle3D  source triangle.
- in_valid  input  1  tri_in valid.
- in_ready  output  1  controller can accept a source triangle.
- depth_cfg  input  3  subdivision level, sampled on accept.
REQ-005 SHALL have these downstream ports:
- tri_out  output  Triangle3D  leaf triangle.
- out_valid  output  1  tri_out valid.
- out_ready  input  1  consumer accepts tri_out.
REQ-006 SHALL have these bisect-datapath and status ports:
- bis_tri_in  output  Triangle3D  triangle driven to bisect.
- bis_tri_select  output  1  0 selects half A, 1 selects half B.
- bis_tri_out  input  Triangle3D  bisect result, registered, 1-cycle latency.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last leaf of a source triangle is accepted.

Function
REQ-007 SHALL hold a LIFO stack of {Triangle3D, level[2:0]} entries with a sp counter (0..STACK_DEPTH).
REQ-008 SHALL implement FSM states IDLE, FETCH, SPLIT_A, SPLIT_B, PUSH_B, PUSH_A, EMIT, FIN.
REQ-009 IDLE: in_ready=1; on in_valid&in_ready, push {tri_in,0}, latch depth_cfg -> FETCH.
REQ-010 FETCH behaviour:
- sp==0 -> FIN.
- Otherwise pop top into work register.
- level==latched depth -> EMIT.
- Else -> SPLIT_A.
REQ-011 SPLIT_A: bis_tri_in=work, bis_tri_select=0 -> SPLIT_B.
REQ-012 SPLIT_B: bis_tri_in=work, bis_tri_select=1; capture bis_tri_out into halfA -> PUSH_B.
REQ-013 PUSH_B: push {bis_tri_out, level+1} (half B) -> PUSH_A.
REQ-014 PUSH_A: push {halfA, level+1} -> FETCH, so half A is emitted before half B (depth-first).
REQ-015 EMIT: out_valid=1, tri_out=work; hold both stable until out_ready; on out_valid&out_ready -> FETCH.
REQ-016 FIN: done=1 for exactly one cycle -> IDLE.
REQ-017 SHALL emit exactly 2^depth leaves per source triangle, in depth-first A-before-B order.
REQ-018 SHALL keep in_ready=0 in all states except IDLE; input is ignored while busy.
REQ-019 SHALL not overflow the stack: the worst case is depth+1 entries, which is at most STACK_DEPTH; push when full and pop when empty SHALL not occur.
REQ-020 SHALL pass triangles bit-exact; the controller performs no arithmetic on vertex data.
REQ-021 For depth 0, out_valid SHALL rise 2 cycles after the accept edge (IDLE -> FETCH -> EMIT).
REQ-022 Leaf spacing SHALL be 4 cycles per split plus 1 FETCH cycle, with zero-wait out_ready.
REQ-023 depth_cfg changes while busy SHALL have no effect until the next accept.

Reset
REQ-024 On rst high, regardless of clk, the block SHALL go to IDLE with these values:
- sp=0.
- out_valid=0, done=0, busy=0.
- in_ready=1.
- bis_tri_select=0.
- tri_out, bis_tri_in, work and halfA all zero.
REQ-025 Reset mid-subdivision SHALL discard all stacked triangles and emit no further leaves.
REQ-026 After rst falls, the first accept SHALL be possible on the first rising edge.

Verification
REQ-027 Depth 0, tri_in=(115,56,0)(346,850,0)(310,450,0), out_ready=1 -> one leaf identical to input 2 cycles after accept; done pulses once.
REQ-028 Depth 1, same triangle, bisect model attached -> two leaves in order (within +-1 LSB):
- A: p(115,56,0), q(230,453,0), r(310,450,0).
- B: p(230,453,0), q(346,850,0), r(310,450,0).
REQ-029 Depth 3 -> exactly 8 leaves; in_ready=0 until done; max sp observed <= 4.
REQ-030 Backpressure: out_ready=0 for 5 cycles during EMIT -> out_valid held, tri_out unchanged, no leaf lost or duplicated.
REQ-031 rst asserted mid-edge in SPLIT_B at depth 2 -> outputs at reset values immediately; a new depth-0 triangle afterward yields exactly one leaf.
REQ-032 in_valid held high while busy -> no second accept until IDLE; depth_cfg changed mid-run does not alter the leaf count.
